// File: rtl/uart_receiver_pkg.sv
// Shared types and constants for the UART receive path.
//   bit_t / uint8_t   : basic scalar and byte types
//   uart_rx_state_t   : receive state machine states
//   UART_DATA_BITS    : data bits per frame
//   UART_IDLE_LEVEL   : level of an idle rx line
package uart_receiver_pkg;

  typedef logic       bit_t;
  typedef logic [7:0] uint8_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_rx_state_t;

  localparam int   UART_DATA_BITS  = 8;
  localparam bit_t UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_rx_sync_edge.sv
// Two-flop synchroniser for the asynchronous rx pin plus falling-edge detect.
// Ports:
//   clk      in   system clock
//   reset    in   synchronous active-high reset; flops return to the idle level
//   async_in in   raw rx line
//   synced   out  synchronised line level
//   fall     out  high for one cycle when synced goes 1 -> 0
module uart_rx_sync_edge
  import uart_receiver_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic synced,
  output logic fall
);

  bit_t sync1_reg;
  bit_t sync2_reg;
  bit_t prev_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg <= UART_IDLE_LEVEL;
      sync2_reg <= UART_IDLE_LEVEL;
      prev_reg  <= UART_IDLE_LEVEL;
    end else begin
      sync1_reg <= async_in;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
    end
  end

  assign synced = sync2_reg;
  assign fall   = prev_reg & ~sync2_reg;

endmodule

// File: rtl/uart_receiver.sv
// UART receive stage: start, 8 data bits LSB first, parity, stop.
// Samples each bit at mid-bit using a down-counting timer and presents the
// byte with a one-cycle rx_valid pulse together with parity/framing flags.
// Ports:
//   clk            in   system clock
//   reset          in   synchronous active-high reset
//   serial_input   in   asynchronous rx line, idle high
//   data_out       out  last received byte, held until the next frame completes
//   rx_valid       out  one-cycle pulse when data_out and the flags update
//   parity_error   out  parity mismatch for the frame in data_out
//   framing_error  out  stop bit sampled low for the frame in data_out
//   busy           out  high from start detection until the frame ends
module uart_receiver
  import uart_receiver_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       serial_input,
  output logic [7:0] data_out,
  output logic       rx_valid,
  output logic       parity_error,
  output logic       framing_error,
  output logic       busy
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] TIMER_FULL = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TIMER_HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]    LAST_BIT   = 3'(UART_DATA_BITS - 1);

  bit_t line_synced;
  bit_t line_fall;

  uart_rx_sync_edge u_sync_edge (
    .clk      (clk),
    .reset    (reset),
    .async_in (serial_input),
    .synced   (line_synced),
    .fall     (line_fall)
  );

  uart_rx_state_t state_reg;
  logic [TW-1:0]  timer_reg;
  logic [2:0]     bit_idx_reg;
  uint8_t         shift_reg;
  bit_t           parity_bit_reg;

  logic timer_expired;
  assign timer_expired = (timer_reg == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      timer_reg      <= '0;
      bit_idx_reg    <= '0;
      shift_reg      <= '0;
      parity_bit_reg <= 1'b0;
      data_out       <= '0;
      rx_valid       <= 1'b0;
      parity_error   <= 1'b0;
      framing_error  <= 1'b0;
      busy           <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          // Edge detection only happens here, so edges inside a frame never resync.
          if (line_fall) begin
            state_reg <= START;
            timer_reg <= TIMER_HALF;
            busy      <= 1'b1;
          end
        end
        START: begin
          if (timer_expired) begin
            if (!line_synced) begin
              state_reg   <= DATA;
              timer_reg   <= TIMER_FULL;
              bit_idx_reg <= '0;
            end else begin
              // Line back high at mid start bit: treat as a glitch.
              state_reg <= IDLE;
              busy      <= 1'b0;
            end
          end else begin
            timer_reg <= timer_reg - 1'b1;
          end
        end
        DATA: begin
          if (timer_expired) begin
            shift_reg[bit_idx_reg] <= line_synced;
            timer_reg              <= TIMER_FULL;
            if (bit_idx_reg == LAST_BIT) begin
              state_reg <= PARITY;
            end else begin
              bit_idx_reg <= bit_idx_reg + 1'b1;
            end
          end else begin
            timer_reg <= timer_reg - 1'b1;
          end
        end
        PARITY: begin
          if (timer_expired) begin
            parity_bit_reg <= line_synced;
            timer_reg      <= TIMER_FULL;
            state_reg      <= STOP;
          end else begin
            timer_reg <= timer_reg - 1'b1;
          end
        end
        STOP: begin
          if (timer_expired) begin
            // Return to IDLE at mid stop bit so a start edge right after
            // the stop bit is still caught.
            state_reg     <= IDLE;
            data_out      <= shift_reg;
            rx_valid      <= 1'b1;
            parity_error  <= ((^shift_reg) ^ PARITY_ODD) != parity_bit_reg;
            framing_error <= ~line_synced;
            busy          <= 1'b0;
          end else begin
            timer_reg <= timer_reg - 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
